// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and parity modes.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      CLEANUP,
      BREAK_WAIT
   } uart_state_e;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   // data_xor is the XOR of all data bits; pbit is the received parity bit.
   function automatic logic parity_mismatch(input int unsigned mode,
                                            input logic        data_xor,
                                            input logic        pbit);
      logic total;
      total = data_xor ^ pbit;
      if (mode == PAR_ODD) begin
         return ~total;
      end else if (mode == PAR_EVEN) begin
         return total;
      end
      return 1'b0;
   endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Two-flop synchroniser for the RX pin with an optional 2-of-3 majority voter.
// UART_RX_MAJORITY_EN selects voting over the samples one cycle either side of the sample point.
module uart_bit_sampler (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Rx_Serial,
   output logic o_Rx_Sync,
   output logic o_Rx_Sample
);

   logic sync1_q;
   logic sync2_q;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= i_Rx_Serial;
         sync2_q <= sync1_q;
      end
   end

   assign o_Rx_Sync = sync2_q;

`ifdef UART_RX_MAJORITY_EN
   // Window {next, current, previous} around the synchronised bit, so the vote
   // is available on the same cycle as the single-sample decision would be.
   logic       prev_q;
   logic [2:0] win;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= sync2_q;
      end
   end

   assign win         = {sync1_q, sync2_q, prev_q};
   assign o_Rx_Sample = (win[2] & win[1]) | (win[2] & win[0]) | (win[1] & win[0]);
`else
   assign o_Rx_Sample = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting of every bit.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 217,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_Rx_Serial,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Rx_Busy
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = (STOP_BITS == 2);

   uart_state_e          state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [IDX_W-1:0]     idx_q;
   logic                 stop_idx_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 par_err_q;
   logic                 frm_err_q;

   logic rx_sync;
   logic rx_sample;
   logic bit_tick;

   uart_bit_sampler u_sampler (
      .i_Clock     (i_Clock),
      .i_Reset     (i_Reset),
      .i_Rx_Serial (i_Rx_Serial),
      .o_Rx_Sync   (rx_sync),
      .o_Rx_Sample (rx_sample)
   );

   assign bit_tick  = (cnt_q == CNT_LAST);
   assign o_Rx_Busy = (state_q != IDLE);

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         stop_idx_q   <= 1'b0;
         data_q       <= '0;
         par_err_q    <= 1'b0;
         frm_err_q    <= 1'b0;
         o_Rx_DV      <= 1'b0;
         o_Rx_Byte    <= '0;
         o_Parity_Err <= 1'b0;
         o_Frame_Err  <= 1'b0;
      end else begin
         // Flags are only meaningful alongside the valid pulse.
         o_Rx_DV      <= 1'b0;
         o_Parity_Err <= 1'b0;
         o_Frame_Err  <= 1'b0;

         case (state_q)
            IDLE: begin
               cnt_q      <= '0;
               idx_q      <= '0;
               stop_idx_q <= 1'b0;
               par_err_q  <= 1'b0;
               frm_err_q  <= 1'b0;
               if (!rx_sync) begin
                  state_q <= START;
               end
            end

            START: begin
               if (cnt_q == CNT_MID) begin
                  cnt_q   <= '0;
                  state_q <= rx_sample ? IDLE : DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            DATA: begin
               if (bit_tick) begin
                  cnt_q  <= '0;
                  data_q <= {rx_sample, data_q[DATA_BITS-1:1]};
                  if (idx_q == IDX_LAST) begin
                     idx_q   <= '0;
                     state_q <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            uart_pkg::PARITY: begin
               if (bit_tick) begin
                  cnt_q     <= '0;
                  par_err_q <= parity_mismatch(PARITY, ^data_q, rx_sample);
                  state_q   <= STOP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            STOP: begin
               if (bit_tick) begin
                  cnt_q <= '0;
                  if (!rx_sample) begin
                     frm_err_q <= 1'b1;
                  end
                  if (stop_idx_q == STOP_LAST) begin
                     state_q      <= CLEANUP;
                     o_Rx_DV      <= 1'b1;
                     o_Rx_Byte    <= data_q;
                     o_Parity_Err <= par_err_q;
                     o_Frame_Err  <= frm_err_q | ~rx_sample;
                  end else begin
                     stop_idx_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            CLEANUP: begin
               // A low stop bit may be a break; wait for the line to recover.
               state_q <= frm_err_q ? BREAK_WAIT : IDLE;
            end

            BREAK_WAIT: begin
               if (rx_sync) begin
                  state_q <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
